// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage program-counter unit.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SRC_SEQ    = 3'd0,
    PC_SRC_JALR   = 3'd1,
    PC_SRC_BRANCH = 3'd2,
    PC_SRC_JAL    = 3'd3,
    PC_SRC_MTVEC  = 3'd4,
    PC_SRC_MEPC   = 3'd5
  } pc_src_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam int          DEFAULT_INCR         = 4;

  // Encodings 6 and 7 are reserved and behave as sequential fetch.
  function automatic pc_src_e decode_src(input logic [2:0] raw);
    pc_src_e src;
    case (raw)
      3'd1:    src = PC_SRC_JALR;
      3'd2:    src = PC_SRC_BRANCH;
      3'd3:    src = PC_SRC_JAL;
      3'd4:    src = PC_SRC_MTVEC;
      3'd5:    src = PC_SRC_MEPC;
      default: src = PC_SRC_SEQ;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection with trap priority, pending fallback and alignment masking.
module pc_next_mux
  import pc_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IALIGN = 4
) (
  input  pc_src_e          src,
  input  logic             trap,
  input  logic             pend_valid,
  input  logic [XLEN-1:0]  pend_target,
  input  logic [XLEN-1:0]  seq_target,
  input  logic [XLEN-1:0]  jalr,
  input  logic [XLEN-1:0]  branch,
  input  logic [XLEN-1:0]  jal,
  input  logic [XLEN-1:0]  mtvec,
  input  logic [XLEN-1:0]  mepc,
  output logic [XLEN-1:0]  target,
  output logic             redirect,
  output logic             misaligned
);

  localparam int ALIGN_BITS = (IALIGN == 2) ? 1 : 2;
  localparam logic [XLEN-1:0] LOW_MASK  = {{(XLEN-ALIGN_BITS){1'b0}}, {ALIGN_BITS{1'b1}}};
  localparam logic [XLEN-1:0] BIT0_MASK = {{(XLEN-1){1'b0}}, 1'b1};

  // Priority select: trap, explicit redirect, held redirect, then sequential.
  always_comb begin
    target     = seq_target;
    redirect   = 1'b0;
    misaligned = 1'b0;
    if (trap) begin
      target   = mtvec & ~LOW_MASK;
      redirect = 1'b1;
    end else begin
      case (src)
        PC_SRC_JALR: begin
          target     = jalr & ~BIT0_MASK;
          redirect   = 1'b1;
          misaligned = |(jalr & ~BIT0_MASK & LOW_MASK);
        end
        PC_SRC_BRANCH: begin
          target     = branch;
          redirect   = 1'b1;
          misaligned = |(branch & LOW_MASK);
        end
        PC_SRC_JAL: begin
          target     = jal;
          redirect   = 1'b1;
          misaligned = |(jal & LOW_MASK);
        end
        PC_SRC_MTVEC: begin
          target   = mtvec & ~LOW_MASK;
          redirect = 1'b1;
        end
        PC_SRC_MEPC: begin
          target   = mepc & ~LOW_MASK;
          redirect = 1'b1;
        end
        default: begin
          if (pend_valid) begin
            target = pend_target;
          end else begin
            target = seq_target;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Registered program counter with fetch handshake, held redirect and
// misaligned-target reporting.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int              IALIGN       = 4,
  parameter int              INCR         = DEFAULT_INCR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_write,
  input  logic [2:0]       pc_source,
  input  logic [XLEN-1:0]  jalr,
  input  logic [XLEN-1:0]  branch,
  input  logic [XLEN-1:0]  jal,
  input  logic [XLEN-1:0]  mtvec,
  input  logic [XLEN-1:0]  mepc,
  input  logic             trap,
  input  logic             fetch_ready,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus_incr,
  output logic             fetch_valid,
  output logic             misalign,
  output logic [XLEN-1:0]  misalign_addr
);

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pend_target_r;
  logic            pend_valid_r;
  logic            fetch_valid_r;
  logic            misalign_r;
  logic [XLEN-1:0] misalign_addr_r;

  logic [XLEN-1:0] target_s;
  logic            redirect_s;
  logic            misaligned_s;
  logic            adv_s;

  assign adv_s        = pc_write & fetch_valid_r & fetch_ready;
  assign pc_plus_incr = pc_r + XLEN'(INCR);

  pc_next_mux #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_next_mux (
    .src         (decode_src(pc_source)),
    .trap        (trap),
    .pend_valid  (pend_valid_r),
    .pend_target (pend_target_r),
    .seq_target  (pc_plus_incr),
    .jalr        (jalr),
    .branch      (branch),
    .jal         (jal),
    .mtvec       (mtvec),
    .mepc        (mepc),
    .target      (target_s),
    .redirect    (redirect_s),
    .misaligned  (misaligned_s)
  );

  // PC, pending redirect and misalignment report registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r            <= RESET_VECTOR;
      pend_target_r   <= {XLEN{1'b0}};
      pend_valid_r    <= 1'b0;
      fetch_valid_r   <= 1'b0;
      misalign_r      <= 1'b0;
      misalign_addr_r <= {XLEN{1'b0}};
    end else begin
      fetch_valid_r <= 1'b1;
      misalign_r    <= misaligned_s;
      if (misaligned_s) begin
        // A bad target is dropped outright and also cancels any held redirect.
        misalign_addr_r <= target_s;
        pend_valid_r    <= 1'b0;
      end else if (adv_s) begin
        pc_r         <= target_s;
        pend_valid_r <= 1'b0;
      end else if (redirect_s) begin
        pend_target_r <= target_s;
        pend_valid_r  <= 1'b1;
      end else begin
        pend_valid_r <= pend_valid_r;
      end
    end
  end

  assign pc            = pc_r;
  assign fetch_valid   = fetch_valid_r;
  assign misalign      = misalign_r;
  assign misalign_addr = misalign_addr_r;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: two instances (IALIGN 4 and 2) share stimulus
// and are compared every cycle against a behavioural model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write, trap, fetch_ready;
  logic [2:0]  pc_source;
  logic [31:0] jalr, branch, jal, mtvec, mepc;

  logic [31:0] pc_a, ppi_a, maddr_a, pc_b, ppi_b, maddr_b;
  logic        fv_a, mis_a, fv_b, mis_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .IALIGN(4), .INCR(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .pc_source(pc_source),
    .jalr(jalr), .branch(branch), .jal(jal), .mtvec(mtvec), .mepc(mepc),
    .trap(trap), .fetch_ready(fetch_ready), .pc(pc_a), .pc_plus_incr(ppi_a),
    .fetch_valid(fv_a), .misalign(mis_a), .misalign_addr(maddr_a)
  );

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .IALIGN(2), .INCR(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .pc_source(pc_source),
    .jalr(jalr), .branch(branch), .jal(jal), .mtvec(mtvec), .mepc(mepc),
    .trap(trap), .fetch_ready(fetch_ready), .pc(pc_b), .pc_plus_incr(ppi_b),
    .fetch_valid(fv_b), .misalign(mis_b), .misalign_addr(maddr_b)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pend;
    logic [31:0] maddr;
    bit          pv;
    bit          fv;
    bit          mis;
  } mstate_t;

  mstate_t m_a, m_b;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic mstate_t mreset();
    mstate_t s;
    s.pc = 32'h100; s.pend = 32'h0; s.maddr = 32'h0;
    s.pv = 1'b0; s.fv = 1'b0; s.mis = 1'b0;
    return s;
  endfunction

  function automatic logic [31:0] align_down(input logic [31:0] v, input logic [31:0] a);
    return v - (v % a);
  endfunction

  // One clock of the architectural behaviour, from the current inputs.
  function automatic mstate_t mstep(input mstate_t s, input logic [31:0] ialign);
    mstate_t     n = s;
    bit          adv = pc_write && s.fv && fetch_ready;
    int          src = (pc_source > 3'd5) ? 0 : int'(pc_source);
    logic [31:0] t;
    bit          redir = 1'b0;
    bit          bad = 1'b0;
    if (trap) begin
      t = align_down(mtvec, ialign); redir = 1'b1;
    end else if (src == 1) begin
      t = align_down(jalr, 32'd2); redir = 1'b1; bad = (t % ialign) != 0;
    end else if (src == 2) begin
      t = branch; redir = 1'b1; bad = (t % ialign) != 0;
    end else if (src == 3) begin
      t = jal; redir = 1'b1; bad = (t % ialign) != 0;
    end else if (src == 4) begin
      t = align_down(mtvec, ialign); redir = 1'b1;
    end else if (src == 5) begin
      t = align_down(mepc, ialign); redir = 1'b1;
    end else begin
      t = s.pv ? s.pend : s.pc + 32'd4;
    end
    n.fv  = 1'b1;
    n.mis = bad;
    if (bad) begin
      n.maddr = t; n.pv = 1'b0;
    end else if (adv) begin
      n.pc = t; n.pv = 1'b0;
    end else if (redir) begin
      n.pend = t; n.pv = 1'b1;
    end
    return n;
  endfunction

  task automatic compare_all();
    check_eq("a_pc", pc_a, m_a.pc);
    check_eq("a_pc_plus_incr", ppi_a, m_a.pc + 32'd4);
    check_eq("a_fetch_valid", {31'd0, fv_a}, {31'd0, m_a.fv});
    check_eq("a_misalign", {31'd0, mis_a}, {31'd0, m_a.mis});
    check_eq("a_misalign_addr", maddr_a, m_a.maddr);
    check_eq("b_pc", pc_b, m_b.pc);
    check_eq("b_pc_plus_incr", ppi_b, m_b.pc + 32'd4);
    check_eq("b_fetch_valid", {31'd0, fv_b}, {31'd0, m_b.fv});
    check_eq("b_misalign", {31'd0, mis_b}, {31'd0, m_b.mis});
    check_eq("b_misalign_addr", maddr_b, m_b.maddr);
  endtask

  task automatic tick();
    m_a = mstep(m_a, 32'd4);
    m_b = mstep(m_b, 32'd2);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic pw, input logic fr, input logic [2:0] ps, input logic tr);
    pc_write = pw; fetch_ready = fr; pc_source = ps; trap = tr;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 3'd0, 1'b0);
    jalr = 32'h0; branch = 32'h0; jal = 32'h0; mtvec = 32'h0; mepc = 32'h0;
    m_a = mreset(); m_b = mreset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();

    // Release and run sequentially.
    rst_n = 1'b1;
    tick();
    check_eq("rel_fetch_valid", {31'd0, fv_a}, 32'd1);
    check_eq("rel_pc", pc_a, 32'h100);
    tick();
    check_eq("seq_104", pc_a, 32'h104);
    tick();
    check_eq("seq_108", pc_a, 32'h108);

    // Stalled JAL is held and applied once the pipeline advances.
    jal = 32'h200; drive(1'b1, 1'b1, 3'd3, 1'b0); tick();
    check_eq("jal_200", pc_a, 32'h200);
    jal = 32'h400; drive(1'b0, 1'b1, 3'd3, 1'b0);
    repeat (3) tick();
    check_eq("stall_hold", pc_a, 32'h200);
    drive(1'b1, 1'b1, 3'd0, 1'b0); tick();
    check_eq("pend_400", pc_a, 32'h400);

    // Later redirect overwrites earlier while fetch is not ready.
    branch = 32'h300; drive(1'b1, 1'b0, 3'd2, 1'b0); tick();
    jalr = 32'h501; drive(1'b1, 1'b0, 3'd1, 1'b0); tick();
    check_eq("ready_low_hold", pc_a, 32'h400);
    drive(1'b1, 1'b1, 3'd0, 1'b0); tick();
    check_eq("jalr_500_a", pc_a, 32'h500);
    check_eq("jalr_500_b", pc_b, 32'h500);

    // Misaligned branch: dropped for IALIGN=4, taken for IALIGN=2.
    branch = 32'h302; drive(1'b1, 1'b1, 3'd2, 1'b0); tick();
    check_eq("mis_pc_a", pc_a, 32'h500);
    check_eq("mis_pulse_a", {31'd0, mis_a}, 32'd1);
    check_eq("mis_addr_a", maddr_a, 32'h302);
    check_eq("mis_pc_b", pc_b, 32'h302);
    check_eq("mis_none_b", {31'd0, mis_b}, 32'd0);
    drive(1'b1, 1'b1, 3'd0, 1'b0); tick();
    check_eq("mis_drop_a", {31'd0, mis_a}, 32'd0);

    // Trap beats a misaligned branch.
    mtvec = 32'h803; branch = 32'h2; drive(1'b1, 1'b1, 3'd2, 1'b1); tick();
    check_eq("trap_pc_a", pc_a, 32'h800);
    check_eq("trap_nomis_a", {31'd0, mis_a}, 32'd0);
    check_eq("trap_pc_b", pc_b, 32'h802);

    // Wrap-around and reserved source encoding.
    jal = 32'hFFFF_FFFC; drive(1'b1, 1'b1, 3'd3, 1'b0); tick();
    drive(1'b1, 1'b1, 3'd0, 1'b0); tick();
    check_eq("wrap_zero", pc_a, 32'h0);
    drive(1'b1, 1'b1, 3'd7, 1'b0); tick();
    check_eq("src7_seq", pc_a, 32'h4);

    // Reset during a stall discards the held redirect.
    jal = 32'h600; drive(1'b1, 1'b0, 3'd3, 1'b0); tick();
    #2 rst_n = 1'b0;
    #1;
    m_a = mreset(); m_b = mreset();
    check_eq("async_rst_pc", pc_a, 32'h100);
    check_eq("async_rst_fv", {31'd0, fv_a}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 3'd0, 1'b0);
    tick();
    tick();
    check_eq("rst_pend_gone", pc_a, 32'h104);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      pc_write    = ($urandom_range(0, 7) != 0);
      fetch_ready = ($urandom_range(0, 3) != 0);
      trap        = ($urandom_range(0, 19) == 0);
      pc_source   = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      jalr   = {$urandom_range(0, 32'hFFFF), 12'h000, 4'($urandom_range(0, 15))};
      branch = {$urandom_range(0, 32'hFFFF), 14'h0000, 2'($urandom_range(0, 3)) & (($urandom_range(0, 2) == 0) ? 2'b11 : 2'b00)};
      jal    = {$urandom_range(0, 32'hFFFF), 14'h0000, 2'($urandom_range(0, 3)) & (($urandom_range(0, 2) == 0) ? 2'b11 : 2'b00)};
      mtvec  = $urandom();
      mepc   = $urandom();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit that replaces the bare next-instruction selector with a registered PC, a fetch handshake, a held pending-redirect register, and misaligned-target detection. It sits at the head of the fetch stage. It takes the same redirect targets as before (jalr, branch, jal, mtvec, mepc) from the execute/CSR logic, and drives the instruction-memory address.

## Interface
- XLEN, 32, width of PC and all targets
- RESET_VECTOR, 0, PC value loaded on reset
- IALIGN, 4, instruction alignment in bytes; 4 or 2 (2 = compressed support)
- INCR, 4, sequential increment added to PC
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- PC_WRITE  in  1  pipeline permits PC to advance (0 = stall)
- PC_SOURCE  in  3  redirect select: 0 seq, 1 jalr, 2 branch, 3 jal, 4 mtvec, 5 mepc, 6–7 treated as 0
- JALR, BRANCH, JAL, MTVEC, MEPC  in  XLEN each  candidate targets
- TRAP  in  1  trap taken; forces MTVEC, overrides PC_SOURCE and pending
- FETCH_READY  in  1  instruction memory accepts current address
- PC  out  XLEN  current fetch address (registered)
- PC_PLUS_INCR  out  XLEN  PC + INCR (combinational)
- FETCH_VALID  out  1  PC is a valid fetch request
- MISALIGN  out  1  one-cycle pulse: requested target not IALIGN-aligned
- MISALIGN_ADDR  out  XLEN  offending target, held until next MISALIGN

## Operation
- adv = PC_WRITE & FETCH_VALID & FETCH_READY.
- Target select, in priority order: TRAP → MTVEC. Otherwise PC_SOURCE 1–5 → the named target. Otherwise pend_valid → pend_target. Otherwise PC_PLUS_INCR.
- JALR target has bit 0 cleared before use. MTVEC and MEPC have their low log2(IALIGN) bits cleared and never flag misalignment.
- Misalignment check applies to JALR (after clearing), BRANCH and JAL: target[log2(IALIGN)-1:0] != 0.
  - The redirect is dropped; PC is unchanged.
  - MISALIGN=1 for one cycle; MISALIGN_ADDR is loaded.
  - pend_valid is cleared.
- On adv: PC ← selected target; pend_valid ← 0.
- Without adv, a valid non-zero PC_SOURCE or TRAP captures its target: pend_target ← target, pend_valid ← 1. A later redirect overwrites an earlier one.
- Sequential selection never writes pending state.
- Arithmetic is modulo 2^XLEN. PC = 2^XLEN − INCR wraps to 0, with no flag.

## Timing
- Reset values (async assert, synchronous-to-CLK deassert use):
  - PC = RESET_VECTOR, PC_PLUS_INCR = RESET_VECTOR + INCR
  - FETCH_VALID = 0, MISALIGN = 0, MISALIGN_ADDR = 0, pend_valid = 0
- FETCH_VALID rises on the first CLK edge after RST_N goes high, then stays at 1.
- Redirect latency: a target presented in cycle n with adv appears on PC in cycle n+1.
- If stalled, the target is held in pending state and appears one cycle after the first adv.
- MISALIGN is asserted in the cycle after the offending request and deasserted one cycle later.
- Handshake: PC must stay stable while FETCH_VALID=1 and FETCH_READY=0.
- TRAP and a misaligned PC_SOURCE in the same cycle: TRAP wins, no MISALIGN.
- RST_N asserted mid-stall discards pend_valid immediately.

## Structure
- Shared package pc_pkg:
  - enum pc_src_e (PC_SRC_SEQ=0, PC_SRC_JALR, PC_SRC_BRANCH, PC_SRC_JAL, PC_SRC_MTVEC, PC_SRC_MEPC)
  - constants DEFAULT_RESET_VECTOR, DEFAULT_INCR
- Sub-module pc_next_mux: combinational, parametrised by XLEN. Selects among sources by pc_src_e and performs the alignment masking. pc_unit instantiates it and owns the PC, pending and misalignment registers.

## Test plan
- Reset with RESET_VECTOR=0x100, release, PC_WRITE=1, FETCH_READY=1, PC_SOURCE=0 → PC sequence 0x100, 0x104, 0x108; FETCH_VALID=0 during reset, 1 on the first edge after release.
- PC=0x200, PC_SOURCE=3, JAL=0x400, PC_WRITE=0 for 3 cycles, then PC_SOURCE=0 and PC_WRITE=1 → PC holds 0x200, then becomes 0x400 one cycle after PC_WRITE rises.
- FETCH_READY=0 with BRANCH=0x300 then JALR=0x501 in consecutive stalled cycles, then ready → PC=0x500 (later redirect wins, bit 0 cleared).
- IALIGN=4, BRANCH=0x302 with adv → PC unchanged, MISALIGN pulses once, MISALIGN_ADDR=0x302; repeat with IALIGN=2 → PC=0x302, no MISALIGN.
- TRAP=1, MTVEC=0x803, PC_SOURCE=2, BRANCH=0x2 → PC=0x800, no MISALIGN.
- PC=0xFFFF_FFFC sequential → PC=0x0; PC_SOURCE=7 → sequential.
